ddr_frame_rx: RTL and testbench
===============================

// Module: ddr_frame_rx
// PURPOSE
// - Consumes the bit pair that ddr_sampler delivers each clk cycle (two line samples per cycle).
// - Reassembles asynchronous-style serial frames into parallel words and presents each word on a valid/ready interface.
// - Sits directly downstream of ddr_sampler in the HPU receive path, in the clkp domain (here: clk).
// PARAMETERS
// - DATA_W  8  data bits per frame, 2..32; any value, not required to be even.
// PORTS
// - clk          in   1       sampler clock (ddr_sampler clkp)
// - rst          in   1       synchronous reset, active-high
// - q1           in   1       earlier line sample of the current cycle
// - q0           in   1       later line sample of the current cycle
// - data_o       out  DATA_W  received word, LSB = first data bit on the line
// - valid_o      out  1       data_o holds an unconsumed word
// - ready_i      in   1       consumer accepts data_o when valid_o && ready_i
// - frame_err_o  out  1       one-cycle pulse: stop bit read as 0, word discarded
// - overrun_o    out  1       one-cycle pulse: completed word dropped, output still full
// - busy_o       out  1       FSM is not in IDLE
// BEHAVIOUR
// - Line format: idle = 1; start = 0; DATA_W data bits, LSB first; stop = 1.
// - Each cycle the FSM steps twice, first on q1 and then on q0. State, shift register and bit count after the q1 step feed the q0 step in the same cycle.
// - States and per-bit transitions:
//   - IDLE: bit 0 -> DATA with cnt = 0. Bit 1 -> stay.
//   - DATA: shift the bit in at the MSB end (right shift), cnt++. When cnt reaches DATA_W -> STOP.
//   - STOP: bit 1 -> word complete, go to IDLE. Bit 0 -> frame error, go to RESYNC.
//   - RESYNC: bit 1 -> IDLE. Bit 0 -> stay. A start bit is never accepted directly out of RESYNC.
// - A start bit may fall on either q1 or q0. Framing holds at either phase, for any DATA_W parity.
// - Back-to-back frames: a stop on q1 followed by a start on q0 in the same cycle must be accepted.
// - Output register:
//   - A word completed in cycle N is loaded into data_o, and valid_o is 1 from cycle N+1.
//   - Latency is 1 clk from the edge that samples the stop-bit pair.
//   - Handshake: valid_o && ready_i at an edge clears valid_o, unless a word completes at the same edge.
//   - If a word completes at the same edge as a handshake, the new word is loaded, valid_o stays 1, and there is no overrun.
//   - If a word completes while valid_o && !ready_i, the new word is dropped, data_o is unchanged, and overrun_o pulses at N+1.
//   - At most one word can complete per cycle, because each frame is at least 4 bits long.
// - frame_err_o pulses 1 cycle after the edge that sampled the bad stop bit.
// - data_o, valid_o and the error pulses change only on clk edges. They are fully registered.
// - Reset:
//   - rst = 1 at an edge forces FSM = IDLE, cnt = 0, data_o = 0, valid_o = 0, frame_err_o = 0, overrun_o = 0, busy_o = 0.
//   - Reset mid-frame discards the partial word.
//   - After reset, the first 0 seen starts a frame.
// - busy_o is registered and equals (state != IDLE) after the edge.
// TESTING
// - DATA_W = 8 throughout. Notation: line bits in time order.
// - Aligned frame:
//   - Stimulus: reset, idle 1s, then line 0 | 1,0,1,0,0,1,0,1 | 1, start bit on q1.
//   - Required: data_o = 8'hA5 and valid_o = 1 one cycle after the stop pair. frame_err_o = 0.
// - Half-cycle offset:
//   - Stimulus: the same frame with the start bit on q0.
//   - Required: data_o = 8'hA5 with the same 1-cycle latency.
// - Back-to-back frames:
//   - Stimulus: 0x3C then 0xC3, with the second start bit in the same cycle as the first stop bit. ready_i = 1.
//   - Required: two valid cycles, 8'h3C then 8'hC3. No error pulses.
// - Framing error:
//   - Stimulus: frame 0x55 with stop bit = 0, line held 0 for 3 cycles, then idle, then a good frame 0x0F.
//   - Required: frame_err_o pulses exactly once, 0x55 is never presented, then data_o = 8'h0F.
// - Overrun:
//   - Stimulus: ready_i = 0, frames 0x11 then 0x22.
//   - Required: data_o stays 8'h11, valid_o stays 1, overrun_o pulses 1 cycle after the 0x22 stop bit.
//   - Then raise ready_i for 1 cycle: valid_o drops.
// - Reset mid-frame:
//   - Stimulus: assert rst for 1 cycle after 4 data bits of 0xFF.
//   - Required: all outputs 0, no word emitted. A following frame 0x81 yields data_o = 8'h81.

Source files
------------

// File: rtl/ddr_frame_rx.sv
// ddr_frame_rx: reassembles start/data/stop serial frames from a two-samples-per-cycle
// line stream and presents completed words on a registered valid/ready interface.
module ddr_frame_rx #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              q1,
    input  logic              q0,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              frame_err_o,
    output logic              overrun_o,
    output logic              busy_o
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        STOP   = 2'd2,
        RESYNC = 2'd3
    } state_t;

    state_t              state_q, state_d, state_mid;
    logic [DATA_W-1:0]   sh_q, sh_d, sh_mid;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_mid;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                frame_err_q, frame_err_d;
    logic                overrun_q, overrun_d;
    logic                busy_q, busy_d;
    logic                done1, done0, err1, err0;
    logic                done, accept;
    logic [DATA_W-1:0]   word;

    // One per-bit step of the frame FSM; applied twice per cycle (q1, then q0).
    function automatic void fsm_step(
        input  state_t            s_in,
        input  logic [DATA_W-1:0] sh_in,
        input  logic [CNT_W-1:0]  cnt_in,
        input  logic              b,
        output state_t            s_out,
        output logic [DATA_W-1:0] sh_out,
        output logic [CNT_W-1:0]  cnt_out,
        output logic              done_out,
        output logic              err_out
    );
        s_out    = s_in;
        sh_out   = sh_in;
        cnt_out  = cnt_in;
        done_out = 1'b0;
        err_out  = 1'b0;
        case (s_in)
            IDLE: begin
                if (!b) begin
                    s_out   = DATA;
                    cnt_out = '0;
                end
            end
            DATA: begin
                sh_out  = {b, sh_in[DATA_W-1:1]};
                cnt_out = cnt_in + CNT_W'(1);
                if (cnt_in == CNT_W'(DATA_W - 1)) begin
                    s_out = STOP;
                end
            end
            STOP: begin
                if (b) begin
                    s_out    = IDLE;
                    done_out = 1'b1;
                end else begin
                    s_out   = RESYNC;
                    err_out = 1'b1;
                end
            end
            RESYNC: begin
                if (b) begin
                    s_out = IDLE;
                end
            end
            default: begin
                s_out = IDLE;
            end
        endcase
    endfunction

    // Two chained FSM steps plus output-register next-state logic.
    always_comb begin
        state_mid   = state_q;
        sh_mid      = sh_q;
        cnt_mid     = cnt_q;
        state_d     = state_q;
        sh_d        = sh_q;
        cnt_d       = cnt_q;
        done1       = 1'b0;
        done0       = 1'b0;
        err1        = 1'b0;
        err0        = 1'b0;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        fsm_step(state_q, sh_q, cnt_q, q1, state_mid, sh_mid, cnt_mid, done1, err1);
        fsm_step(state_mid, sh_mid, cnt_mid, q0, state_d, sh_d, cnt_d, done0, err0);

        done   = done1 | done0;
        word   = done1 ? sh_mid : sh_d;
        accept = valid_q & ready_i;

        if (done) begin
            if (!valid_q || ready_i) begin
                data_d  = word;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (accept) begin
            valid_d = 1'b0;
        end

        frame_err_d = err1 | err0;
        busy_d      = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sh_q        <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_ddr_frame_rx.sv
// Directed self-checking bench for ddr_frame_rx with DATA_W = 8.
module tb_ddr_frame_rx;

    logic       clk;
    logic       rst;
    logic       q1;
    logic       q0;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic       frame_err_o;
    logic       overrun_o;
    logic       busy_o;

    int n_cmp;
    int n_bad;

    // Line stream and per-run observation log
    logic       line[$];
    logic [7:0] got[$];
    int         n_err;
    int         n_ovr;
    int         first_valid;
    int         ovr_cyc;
    int         cyc;

    ddr_frame_rx #(.DATA_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .q1          (q1),
        .q0          (q0),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) line.push_back(1'b1);
    endtask

    task automatic add_frame(input logic [7:0] d, input logic stop);
        line.push_back(1'b0);
        for (int i = 0; i < 8; i++) line.push_back(d[i]);
        line.push_back(stop);
    endtask

    task automatic clear_log();
        got.delete();
        n_err       = 0;
        n_ovr       = 0;
        first_valid = -1;
        ovr_cyc     = -1;
        cyc         = 0;
    endtask

    // Drive one pair, then sample 1 time unit after the edge that consumed it
    task automatic do_pair(input logic b1, input logic b0);
        @(negedge clk);
        q1 = b1;
        q0 = b0;
        @(posedge clk);
        #1;
    endtask

    task automatic run_line();
        logic b1, b0;
        int   idx;
        if (line.size() % 2 != 0) line.push_back(1'b1);
        while (line.size() > 0) begin
            b1 = line.pop_front();
            b0 = line.pop_front();
            do_pair(b1, b0);
            idx = cyc;
            cyc++;
            if (frame_err_o) n_err++;
            if (overrun_o) begin
                n_ovr++;
                ovr_cyc = idx;
            end
            if (valid_o) begin
                if (first_valid < 0) first_valid = idx;
                if (ready_i) got.push_back(data_o);
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        q1  = 1'b1;
        q0  = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b want=0", valid_o); end
        n_cmp++; if (data_o !== 8'h00) begin n_bad++; $display("FAIL reset_data got=%h want=00", data_o); end
        n_cmp++; if (frame_err_o !== 1'b0) begin n_bad++; $display("FAIL reset_ferr got=%b want=0", frame_err_o); end
        n_cmp++; if (overrun_o !== 1'b0) begin n_bad++; $display("FAIL reset_ovr got=%b want=0", overrun_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy_o); end
    endtask

    task automatic test_aligned();
        clear_log();
        add_idle(4);
        add_frame(8'hA5, 1'b1);
        add_idle(2);
        run_line();
        n_cmp++; if (first_valid != 6) begin n_bad++; $display("FAIL aligned_latency got=%0d want=6", first_valid); end
        n_cmp++; if (got.size() != 1 || got[0] !== 8'hA5) begin n_bad++; $display("FAIL aligned_data words=%0d first=%h want=1 word A5", got.size(), (got.size() > 0) ? got[0] : 8'hxx); end
        n_cmp++; if (n_err != 0) begin n_bad++; $display("FAIL aligned_ferr got=%0d want=0", n_err); end
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL aligned_busy got=%b want=0", busy_o); end
    endtask

    task automatic test_half_offset();
        clear_log();
        add_idle(3);
        add_frame(8'hA5, 1'b1);
        add_idle(3);
        run_line();
        n_cmp++; if (first_valid != 6) begin n_bad++; $display("FAIL half_latency got=%0d want=6", first_valid); end
        n_cmp++; if (got.size() != 1 || got[0] !== 8'hA5) begin n_bad++; $display("FAIL half_data words=%0d first=%h want=1 word A5", got.size(), (got.size() > 0) ? got[0] : 8'hxx); end
        n_cmp++; if (n_err != 0) begin n_bad++; $display("FAIL half_ferr got=%0d want=0", n_err); end
    endtask

    task automatic test_back_to_back();
        clear_log();
        add_idle(1);
        add_frame(8'h3C, 1'b1);
        add_frame(8'hC3, 1'b1);
        add_idle(3);
        run_line();
        n_cmp++; if (first_valid != 5) begin n_bad++; $display("FAIL b2b_latency got=%0d want=5", first_valid); end
        n_cmp++; if (got.size() != 2) begin n_bad++; $display("FAIL b2b_count got=%0d want=2", got.size()); end
        n_cmp++; if (got.size() < 1 || got[0] !== 8'h3C) begin n_bad++; $display("FAIL b2b_word0 got=%h want=3C", (got.size() > 0) ? got[0] : 8'hxx); end
        n_cmp++; if (got.size() < 2 || got[1] !== 8'hC3) begin n_bad++; $display("FAIL b2b_word1 got=%h want=C3", (got.size() > 1) ? got[1] : 8'hxx); end
        n_cmp++; if (n_err != 0 || n_ovr != 0) begin n_bad++; $display("FAIL b2b_errors ferr=%0d ovr=%0d want=0/0", n_err, n_ovr); end
    endtask

    task automatic test_framing_error();
        clear_log();
        add_idle(2);
        add_frame(8'h55, 1'b0);
        for (int i = 0; i < 6; i++) line.push_back(1'b0);
        add_idle(4);
        add_frame(8'h0F, 1'b1);
        add_idle(2);
        run_line();
        n_cmp++; if (n_err != 1) begin n_bad++; $display("FAIL ferr_pulses got=%0d want=1", n_err); end
        n_cmp++; if (got.size() != 1 || got[0] !== 8'h0F) begin n_bad++; $display("FAIL ferr_data words=%0d first=%h want=1 word 0F", got.size(), (got.size() > 0) ? got[0] : 8'hxx); end
        n_cmp++; if (n_ovr != 0) begin n_bad++; $display("FAIL ferr_ovr got=%0d want=0", n_ovr); end
    endtask

    task automatic test_overrun();
        clear_log();
        ready_i = 1'b0;
        add_idle(2);
        add_frame(8'h11, 1'b1);
        add_idle(2);
        add_frame(8'h22, 1'b1);
        add_idle(2);
        run_line();
        n_cmp++; if (first_valid != 5) begin n_bad++; $display("FAIL ovr_first_valid got=%0d want=5", first_valid); end
        n_cmp++; if (n_ovr != 1) begin n_bad++; $display("FAIL ovr_pulses got=%0d want=1", n_ovr); end
        n_cmp++; if (ovr_cyc != 11) begin n_bad++; $display("FAIL ovr_timing got=%0d want=11", ovr_cyc); end
        n_cmp++; if (valid_o !== 1'b1) begin n_bad++; $display("FAIL ovr_valid got=%b want=1", valid_o); end
        n_cmp++; if (data_o !== 8'h11) begin n_bad++; $display("FAIL ovr_data got=%h want=11", data_o); end
        ready_i = 1'b1;
        add_idle(2);
        run_line();
        n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL ovr_drain got=%b want=0", valid_o); end
        n_cmp++; if (n_ovr != 1) begin n_bad++; $display("FAIL ovr_after_drain got=%0d want=1", n_ovr); end
    endtask

    task automatic test_reset_mid_frame();
        clear_log();
        add_idle(1);
        line.push_back(1'b0);
        for (int i = 0; i < 4; i++) line.push_back(1'b1);
        run_line();
        n_cmp++; if (busy_o !== 1'b1) begin n_bad++; $display("FAIL mid_busy_before got=%b want=1", busy_o); end
        apply_reset();
        n_cmp++; if (data_o !== 8'h00) begin n_bad++; $display("FAIL mid_data got=%h want=00", data_o); end
        n_cmp++; if (valid_o !== 1'b0 || busy_o !== 1'b0) begin n_bad++; $display("FAIL mid_valid_busy got=%b/%b want=0/0", valid_o, busy_o); end
        n_cmp++; if (frame_err_o !== 1'b0 || overrun_o !== 1'b0) begin n_bad++; $display("FAIL mid_pulses got=%b/%b want=0/0", frame_err_o, overrun_o); end
        clear_log();
        add_idle(2);
        add_frame(8'h81, 1'b1);
        add_idle(2);
        run_line();
        n_cmp++; if (got.size() != 1 || got[0] !== 8'h81) begin n_bad++; $display("FAIL mid_next_frame words=%0d first=%h want=1 word 81", got.size(), (got.size() > 0) ? got[0] : 8'hxx); end
        n_cmp++; if (n_err != 0) begin n_bad++; $display("FAIL mid_ferr got=%0d want=0", n_err); end
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        rst     = 1'b1;
        q1      = 1'b1;
        q0      = 1'b1;
        ready_i = 1'b1;
        clear_log();
        repeat (2) @(posedge clk);
        test_reset();
        test_aligned();
        test_half_offset();
        test_back_to_back();
        test_framing_error();
        test_overrun();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
